ps2_keys: RTL and testbench

Receives the PS/2 keyboard serial stream, decodes make/break scan codes and holds the 4-bit level-sensitive `keys` vector consumed by the kid block and its state updater. It sits between the board's PS/2 pins and the game logic, running in the system clock domain. Key state persists until the matching break code arrives, so a held key stays asserted for as many update ticks as it is held.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_rx.sv | 166 ++++++++++++++++
 rtl/ps2_keys.sv | 67 ++++++
 tb/tb_ps2_keys.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard receiver: scan codes, key-bit indices,
// receiver FSM encoding and the frame parity helper.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_JUMP  = 8'h12;
  localparam logic [7:0] SC_SHOOT = 8'h1A;

  localparam logic [1:0] K_LEFT  = 2'd0;
  localparam logic [1:0] K_RIGHT = 2'd1;
  localparam logic [1:0] K_JUMP  = 2'd2;
  localparam logic [1:0] K_SHOOT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  // PS/2 uses odd parity over the 8 data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, clock glitch filter, falling-edge
// strobe, 11-bit frame FSM with mid-frame timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int FW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
  localparam logic [15:0]   TMO_MAX  = 16'(TIMEOUT_CYC);

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_filt, r_filt_d;
  logic [FW-1:0] r_filt_cnt;
  rx_state_t     r_state, w_state_nxt;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic          r_par;
  logic [15:0]   r_tmo_cnt;
  logic          r_byte_valid, r_frame_err;
  logic [7:0]    r_byte_data;
  logic          w_fall, w_tmo, w_valid_nxt, w_err_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Level follows the synced clock only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_filt_d <= r_filt;
      if (r_clk_s2 == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_MAX) begin
        r_filt     <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  assign w_fall = r_filt_d & ~r_filt;
  assign w_tmo  = (r_state != ST_IDLE) && (r_tmo_cnt == TMO_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    if (w_fall) begin
      case (r_state)
        ST_IDLE: begin
          if (!r_dat_s2) begin
            w_state_nxt = ST_DATA;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        ST_DATA: begin
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = ST_PARITY;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
        ST_PARITY: w_state_nxt = ST_STOP;
        ST_STOP: begin
          if (r_dat_s2 && odd_parity_ok(r_shift, r_par)) begin
            w_valid_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (w_tmo) begin
      w_state_nxt = ST_IDLE;
      w_err_nxt   = 1'b1;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // A fall strobe in the expiry cycle takes priority and restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= 16'd0;
    end else if (w_fall || w_tmo || (r_state == ST_IDLE)) begin
      r_tmo_cnt <= 16'd0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift      <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_par        <= 1'b0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_byte_data  <= 8'h00;
    end else begin
      r_byte_valid <= w_valid_nxt;
      r_frame_err  <= w_err_nxt;
      if (w_valid_nxt) begin
        r_byte_data <= r_shift;
      end
      if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
          end
          ST_DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          ST_PARITY: r_par <= r_dat_s2;
          default:   r_par <= r_par;
        endcase
      end else if (w_tmo) begin
        r_shift   <= 8'h00;
        r_bit_cnt <= 3'd0;
      end
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_data;
  assign frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_keys.sv
// PS/2 keyboard front end: receives scan-code bytes and maintains the held-key
// vector from make/break sequences (with E0/F0 prefix tracking).
module ps2_keys
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] keys,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  logic       w_byte_valid, w_frame_err;
  logic [7:0] w_byte_data;
  logic       r_ext, r_brk;
  logic [3:0] r_keys;

  ps2_rx #(
    .FILT_LEN   (FILT_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(w_byte_valid),
    .byte_data (w_byte_data),
    .frame_err (w_frame_err)
  );

  // Prefix bytes only arm flags; any other byte consumes and clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_keys <= 4'b0000;
    end else if (w_byte_valid) begin
      case (w_byte_data)
        SC_EXT: r_ext <= 1'b1;
        SC_BRK: r_brk <= 1'b1;
        default: begin
          case ({r_ext, w_byte_data})
            {1'b1, SC_LEFT}:  r_keys[K_LEFT]  <= ~r_brk;
            {1'b1, SC_RIGHT}: r_keys[K_RIGHT] <= ~r_brk;
            {1'b0, SC_JUMP}:  r_keys[K_JUMP]  <= ~r_brk;
            {1'b0, SC_SHOOT}: r_keys[K_SHOOT] <= ~r_brk;
            default:          r_keys <= r_keys;
          endcase
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      endcase
    end
  end

  assign keys       = r_keys;
  assign byte_valid = w_byte_valid;
  assign byte_data  = w_byte_data;
  assign frame_err  = w_frame_err;

endmodule

// File: tb/tb_ps2_keys.sv
// Self-checking bench for ps2_keys: bit-level PS/2 frame driver, byte/error
// scoreboard and per-scenario key-vector checks.
module tb_ps2_keys;
  import ps2_pkg::*;

  localparam int HALF = 10;
  localparam int FILT = 4;
  localparam int TMO  = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] keys;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_fall = 0;
  int   n_err = 0;

  ps2_keys #(.FILT_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keys      (keys),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dut.u_rx.w_fall) n_fall++;
  end

  // Scoreboard: every byte_valid / frame_err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && (byte_valid || frame_err)) begin
      if (frame_err) n_err++;
      n_cmp++;
      if (byte_valid && frame_err) begin
        $display("FAIL sb_both: byte_valid=%b frame_err=%b, required not both high", byte_valid, frame_err);
        n_bad++;
      end else if (q.size() == 0) begin
        $display("FAIL sb_unexpected: valid=%b err=%b data=%h, required no output", byte_valid, frame_err, byte_data);
        n_bad++;
      end else begin
        m_e = q.pop_front();
        if (frame_err !== m_e.is_err || (!m_e.is_err && byte_data !== m_e.data)) begin
          $display("FAIL sb_byte: err=%b data=%h, required err=%b data=%h", frame_err, byte_data, m_e.is_err, m_e.data);
          n_bad++;
        end
      end
    end
  end

  task automatic send_bit(input logic b, input logic glitch);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    if (glitch) begin
      ps2_clk = 1'b0;
      repeat (FILT - 1) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad, input int glitch_bit);
    exp_t e;
    e.is_err = bad;
    e.data   = d;
    q.push_back(e);
    send_bit(1'b0, glitch_bit == 0);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch_bit == i + 1);
    send_bit((~^d) ^ bad, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (keys !== 4'b0000 || byte_valid !== 1'b0 || frame_err !== 1'b0 || byte_data !== 8'h00) begin
      $display("FAIL reset: keys=%b v=%b e=%b d=%h, required 0000 0 0 00", keys, byte_valid, frame_err, byte_data);
      n_bad++;
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_make_ext;
    logic seen;
    send_frame(SC_EXT, 1'b0, -1);
    n_cmp++;
    if (keys !== 4'b0000) begin
      $display("FAIL make_prefix: keys=%b, required 0000", keys);
      n_bad++;
    end
    seen = 1'b0;
    fork
      send_frame(SC_LEFT, 1'b0, -1);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (byte_valid) begin
            seen = 1'b1;
            break;
          end
        end
        n_cmp++;
        if (!seen) begin
          $display("FAIL make_wait: byte_valid never seen, required a pulse within 400 cycles");
          n_bad++;
        end else begin
          if (keys !== 4'b0000) begin
            $display("FAIL make_latency: keys=%b in valid cycle, required 0000", keys);
            n_bad++;
          end
          @(negedge clk);
          n_cmp++;
          if (keys !== 4'b0001) begin
            $display("FAIL make_left: keys=%b, required 0001", keys);
            n_bad++;
          end
        end
      end
    join
  endtask

  task automatic test_break_ext;
    send_frame(SC_EXT, 1'b0, -1);
    send_frame(SC_BRK, 1'b0, -1);
    send_frame(SC_LEFT, 1'b0, -1);
    n_cmp++;
    if (keys !== 4'b0000) begin
      $display("FAIL break_left: keys=%b, required 0000", keys);
      n_bad++;
    end
  endtask

  task automatic test_typematic;
    logic [7:0] codes [7];
    logic [3:0] exp_k [7];
    codes = '{SC_LEFT, SC_JUMP, SC_SHOOT, SC_JUMP, SC_SHOOT, SC_BRK, SC_JUMP};
    exp_k = '{4'b0000, 4'b0100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1000};
    for (int i = 0; i < 7; i++) begin
      send_frame(codes[i], 1'b0, -1);
      n_cmp++;
      if (keys !== exp_k[i]) begin
        $display("FAIL typematic_%0d: code=%h keys=%b, required %b", i, codes[i], keys, exp_k[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_bad_parity;
    send_frame(SC_RIGHT, 1'b1, -1);
    n_cmp++;
    if (keys !== 4'b1000) begin
      $display("FAIL badpar_keys: keys=%b, required 1000", keys);
      n_bad++;
    end
    send_frame(SC_EXT, 1'b0, -1);
    send_frame(SC_RIGHT, 1'b0, -1);
    n_cmp++;
    if (keys !== 4'b1010) begin
      $display("FAIL badpar_recover: keys=%b, required 1010", keys);
      n_bad++;
    end
    send_frame(SC_EXT, 1'b0, -1);
    send_frame(SC_BRK, 1'b0, -1);
    send_frame(8'h33, 1'b1, -1);
    send_frame(SC_RIGHT, 1'b0, -1);
    n_cmp++;
    if (keys !== 4'b1000) begin
      $display("FAIL err_keeps_prefix: keys=%b, required 1000", keys);
      n_bad++;
    end
  endtask

  task automatic test_timeout;
    int   e0;
    exp_t e;
    send_frame(SC_BRK, 1'b0, -1);
    send_frame(SC_SHOOT, 1'b0, -1);
    n_cmp++;
    if (keys !== 4'b0000) begin
      $display("FAIL tmo_pre: keys=%b, required 0000", keys);
      n_bad++;
    end
    e0 = n_err;
    e.is_err = 1'b1;
    e.data   = 8'h00;
    q.push_back(e);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    repeat (TMO / 2) @(negedge clk);
    n_cmp++;
    if (n_err !== e0) begin
      $display("FAIL tmo_early: errors=%0d, required %0d", n_err, e0);
      n_bad++;
    end
    repeat (TMO) @(negedge clk);
    n_cmp++;
    if (n_err !== e0 + 1) begin
      $display("FAIL tmo_fire: errors=%0d, required %0d", n_err, e0 + 1);
      n_bad++;
    end
    send_frame(SC_SHOOT, 1'b0, -1);
    n_cmp++;
    if (keys !== 4'b1000) begin
      $display("FAIL tmo_recover: keys=%b, required 1000", keys);
      n_bad++;
    end
  endtask

  task automatic test_glitch;
    int f0;
    f0 = n_fall;
    send_frame(SC_EXT, 1'b0, 4);
    n_cmp++;
    if (n_fall - f0 !== 11) begin
      $display("FAIL glitch_falls: falls=%0d, required 11", n_fall - f0);
      n_bad++;
    end
    send_frame(SC_LEFT, 1'b0, -1);
    n_cmp++;
    if (keys !== 4'b1001) begin
      $display("FAIL glitch_keys: keys=%b, required 1001", keys);
      n_bad++;
    end
  endtask

  task automatic test_reset_mid_frame;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (keys !== 4'b0000 || byte_valid !== 1'b0 || frame_err !== 1'b0) begin
      $display("FAIL rst_mid_out: keys=%b v=%b e=%b, required 0000 0 0", keys, byte_valid, frame_err);
      n_bad++;
    end
    n_cmp++;
    if (dut.u_rx.r_state !== ST_IDLE) begin
      $display("FAIL rst_mid_state: state=%0d, required %0d", dut.u_rx.r_state, ST_IDLE);
      n_bad++;
    end
    ps2_data = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(SC_JUMP, 1'b0, -1);
    n_cmp++;
    if (keys !== 4'b0100) begin
      $display("FAIL rst_mid_recover: keys=%b, required 0100", keys);
      n_bad++;
    end
  endtask

  initial begin
    test_reset();
    test_make_ext();
    test_break_ext();
    test_typematic();
    test_bad_parity();
    test_timeout();
    test_glitch();
    test_reset_mid_frame();
    repeat (20) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      $display("FAIL sb_leftover: %0d outputs outstanding, required 0", q.size());
      n_bad++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
